// File: rtl/banco_pkg.sv
// Shared types and widths for the banco register-bank write path.
package banco_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } grant_e;

endpackage

// File: rtl/banco_wr_fifo.sv
// Synchronous FIFO of write requests for the non-stallable load-return port.
module banco_wr_fifo
    import banco_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  wr_req_t                      push_req,
    input  logic                         pop,
    output wr_req_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wr_req_t         mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok;
    logic            pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // When full, a same-cycle pop frees the slot the push overwrites; the
    // head is consumed combinationally before the edge that rewrites it.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign ovf     = push && full && !pop_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
        else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_req;
    end

endmodule

// File: rtl/banco_wr_arbiter.sv
// Round-robin arbiter sharing the banco write port between ALU results (A) and buffered load returns (B).
module banco_wr_arbiter
    import banco_pkg::*;
#(
    parameter int unsigned B_DEPTH      = 2,
    parameter bit          ZERO_PROTECT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [REG_AW-1:0] a_addr,
    input  logic [REG_DW-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [REG_AW-1:0] b_addr,
    input  logic [REG_DW-1:0] b_data,
    output logic              b_full,
    output logic              b_ovf,
    output logic              RegEn,
    output logic [REG_AW-1:0] aw,
    output logic [REG_DW-1:0] dataIn_b
);

    wr_req_t                        b_push_req;
    wr_req_t                        b_head;
    wr_req_t                        win;
    logic [$clog2(B_DEPTH+1)-1:0]   b_count;
    logic                           b_empty;
    logic                           b_pend;
    logic                           b_pop;
    logic                           fifo_ovf;
    grant_e                         grant;

    logic              regen_q, regen_d;
    logic [REG_AW-1:0] aw_q, aw_d;
    logic [REG_DW-1:0] data_q, data_d;
    logic              last_b_q, last_b_d;
    logic              b_ovf_q, b_ovf_d;

    assign b_push_req.addr = b_addr;
    assign b_push_req.data = b_data;

    banco_wr_fifo #(
        .DEPTH (B_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (b_valid),
        .push_req (b_push_req),
        .pop      (b_pop),
        .head     (b_head),
        .count    (b_count),
        .full     (b_full),
        .empty    (b_empty),
        .ovf      (fifo_ovf)
    );

    assign b_pend = !b_empty;

    always_comb begin
        if (rst_n) assert (b_empty == (b_count == '0));
    end

    always_comb begin
        grant = GNT_NONE;
        if (a_valid && (!b_pend || last_b_q)) grant = GNT_A;
        else if (b_pend)                      grant = GNT_B;
    end

    assign a_ready = (grant == GNT_A);
    assign b_pop   = (grant == GNT_B);

    always_comb begin
        win.addr = a_addr;
        win.data = a_data;
        if (grant == GNT_B) win = b_head;
    end

    always_comb begin
        regen_d  = 1'b0;
        aw_d     = aw_q;
        data_d   = data_q;
        last_b_d = last_b_q;
        b_ovf_d  = b_ovf_q | fifo_ovf;
        if (grant != GNT_NONE) begin
            aw_d     = win.addr;
            data_d   = win.data;
            regen_d  = !(ZERO_PROTECT && (win.addr == '0));
            last_b_d = (grant == GNT_B);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regen_q  <= 1'b0;
            aw_q     <= '0;
            data_q   <= '0;
            last_b_q <= 1'b1;
            b_ovf_q  <= 1'b0;
        end else begin
            regen_q  <= regen_d;
            aw_q     <= aw_d;
            data_q   <= data_d;
            last_b_q <= last_b_d;
            b_ovf_q  <= b_ovf_d;
        end
    end

    assign RegEn    = regen_q;
    assign aw       = aw_q;
    assign dataIn_b = data_q;
    assign b_ovf    = b_ovf_q;

endmodule

// File: tb/tb_banco_wr_arbiter.sv
// Directed self-checking bench for banco_wr_arbiter; inputs change on negedge, checks follow by #1.
module tb_banco_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_full;
    logic        b_ovf;
    logic        RegEn;
    logic [4:0]  aw;
    logic [31:0] dataIn_b;

    int checks = 0;
    int passed = 0;

    banco_wr_arbiter #(
        .B_DEPTH      (2),
        .ZERO_PROTECT (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_valid  (a_valid),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .b_full   (b_full),
        .b_ovf    (b_ovf),
        .RegEn    (RegEn),
        .aw       (aw),
        .dataIn_b (dataIn_b)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        end
        #1;
        checks++; if (RegEn !== 1'b0) $display("FAIL rst_regen: got %0b exp 0", RegEn); else passed++;
        checks++; if (aw !== 5'd0) $display("FAIL rst_aw: got %0d exp 0", aw); else passed++;
        checks++; if (dataIn_b !== 32'd0) $display("FAIL rst_data: got %h exp 0", dataIn_b); else passed++;
        checks++; if (b_ovf !== 1'b0) $display("FAIL rst_ovf: got %0b exp 0", b_ovf); else passed++;
        checks++; if (b_full !== 1'b0) $display("FAIL rst_full: got %0b exp 0", b_full); else passed++;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        #1;
        checks++; if (a_ready !== 1'b1) $display("FAIL rst_a_ready: got %0b exp 1", a_ready); else passed++;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (RegEn !== 1'b1) $display("FAIL rst_a_regen: got %0b exp 1", RegEn); else passed++;
        checks++; if (aw !== 5'd5) $display("FAIL rst_a_aw: got %0d exp 5", aw); else passed++;
        checks++; if (dataIn_b !== 32'hDEADBEEF) $display("FAIL rst_a_data: got %h exp deadbeef", dataIn_b); else passed++;
        @(negedge clk);
        #1;
        checks++; if (RegEn !== 1'b0) $display("FAIL rst_a_pulse_end: got %0b exp 0", RegEn); else passed++;
    endtask

    task automatic test_contention();
        do_reset();
        @(negedge clk);
        drive(0, 0, 0, 1, 5'd7, 32'h11);
        #1;
        checks++; if (a_ready !== 1'b0) $display("FAIL cont_c0_ready: got %0b exp 0", a_ready); else passed++;
        @(negedge clk);
        drive(1, 5'd3, 32'h22, 0, 0, 0);
        #1;
        checks++; if (a_ready !== 1'b1) $display("FAIL cont_c1_ready: got %0b exp 1", a_ready); else passed++;
        @(negedge clk);
        #1;
        checks++; if (a_ready !== 1'b0) $display("FAIL cont_c2_ready: got %0b exp 0", a_ready); else passed++;
        checks++; if (RegEn !== 1'b1 || aw !== 5'd3) $display("FAIL cont_w1: got en=%0b aw=%0d exp en=1 aw=3", RegEn, aw); else passed++;
        @(negedge clk);
        #1;
        checks++; if (a_ready !== 1'b1) $display("FAIL cont_c3_ready: got %0b exp 1", a_ready); else passed++;
        checks++; if (RegEn !== 1'b1 || aw !== 5'd7 || dataIn_b !== 32'h11) $display("FAIL cont_w2: got en=%0b aw=%0d d=%h exp en=1 aw=7 d=11", RegEn, aw, dataIn_b); else passed++;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (RegEn !== 1'b1 || aw !== 5'd3 || dataIn_b !== 32'h22) $display("FAIL cont_w3: got en=%0b aw=%0d d=%h exp en=1 aw=3 d=22", RegEn, aw, dataIn_b); else passed++;
        @(negedge clk);
        #1;
        checks++; if (RegEn !== 1'b0) $display("FAIL cont_idle: got %0b exp 0", RegEn); else passed++;
    endtask

    task automatic test_fifo_full();
        do_reset();
        @(negedge clk);
        drive(0, 0, 0, 1, 5'd10, 32'hA0);
        #1;
        checks++; if (b_full !== 1'b0) $display("FAIL full_c0: got %0b exp 0", b_full); else passed++;
        @(negedge clk);
        drive(1, 5'd1, 32'h100, 1, 5'd11, 32'hB0);
        #1;
        checks++; if (a_ready !== 1'b1 || b_full !== 1'b0) $display("FAIL full_c1: got rdy=%0b full=%0b exp rdy=1 full=0", a_ready, b_full); else passed++;
        @(negedge clk);
        drive(1, 5'd1, 32'h100, 1, 5'd12, 32'hC0);
        #1;
        checks++; if (b_full !== 1'b1) $display("FAIL full_two_pushes: got %0b exp 1", b_full); else passed++;
        checks++; if (a_ready !== 1'b0) $display("FAIL full_c2_ready: got %0b exp 0", a_ready); else passed++;
        checks++; if (RegEn !== 1'b1 || aw !== 5'd1) $display("FAIL full_w1: got en=%0b aw=%0d exp en=1 aw=1", RegEn, aw); else passed++;
        @(negedge clk);
        drive(1, 5'd1, 32'h100, 0, 0, 0);
        #1;
        checks++; if (b_full !== 1'b1 || b_ovf !== 1'b0) $display("FAIL full_push_pop: got full=%0b ovf=%0b exp full=1 ovf=0", b_full, b_ovf); else passed++;
        checks++; if (a_ready !== 1'b1) $display("FAIL full_c3_ready: got %0b exp 1", a_ready); else passed++;
        checks++; if (aw !== 5'd10 || dataIn_b !== 32'hA0) $display("FAIL full_w2: got aw=%0d d=%h exp aw=10 d=a0", aw, dataIn_b); else passed++;
        @(negedge clk);
        #1;
        checks++; if (a_ready !== 1'b0 || aw !== 5'd1) $display("FAIL full_c4: got rdy=%0b aw=%0d exp rdy=0 aw=1", a_ready, aw); else passed++;
        @(negedge clk);
        #1;
        checks++; if (a_ready !== 1'b1 || aw !== 5'd11 || b_full !== 1'b0) $display("FAIL full_c5: got rdy=%0b aw=%0d full=%0b exp rdy=1 aw=11 full=0", a_ready, aw, b_full); else passed++;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (aw !== 5'd1) $display("FAIL full_c6: got aw=%0d exp 1", aw); else passed++;
        @(negedge clk);
        #1;
        checks++; if (RegEn !== 1'b1 || aw !== 5'd12 || dataIn_b !== 32'hC0) $display("FAIL full_w_third: got en=%0b aw=%0d d=%h exp en=1 aw=12 d=c0", RegEn, aw, dataIn_b); else passed++;
        @(negedge clk);
        #1;
        checks++; if (RegEn !== 1'b0 || b_ovf !== 1'b0) $display("FAIL full_drained: got en=%0b ovf=%0b exp en=0 ovf=0", RegEn, b_ovf); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        @(negedge clk);
        drive(0, 0, 0, 1, 5'd20, 32'h2000);
        @(negedge clk);
        drive(1, 5'd2, 32'h200, 1, 5'd21, 32'h2100);
        #1;
        checks++; if (a_ready !== 1'b1) $display("FAIL ovf_c1_ready: got %0b exp 1", a_ready); else passed++;
        @(negedge clk);
        drive(1, 5'd2, 32'h200, 1, 5'd22, 32'h2200);
        #1;
        checks++; if (a_ready !== 1'b0 || b_full !== 1'b1) $display("FAIL ovf_c2: got rdy=%0b full=%0b exp rdy=0 full=1", a_ready, b_full); else passed++;
        @(negedge clk);
        drive(1, 5'd2, 32'h200, 1, 5'd23, 32'h2300);
        #1;
        checks++; if (a_ready !== 1'b1 || b_ovf !== 1'b0) $display("FAIL ovf_c3: got rdy=%0b ovf=%0b exp rdy=1 ovf=0", a_ready, b_ovf); else passed++;
        checks++; if (aw !== 5'd20) $display("FAIL ovf_w20: got aw=%0d exp 20", aw); else passed++;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (b_ovf !== 1'b1) $display("FAIL ovf_set: got %0b exp 1", b_ovf); else passed++;
        checks++; if (aw !== 5'd2) $display("FAIL ovf_w2: got aw=%0d exp 2", aw); else passed++;
        @(negedge clk);
        #1;
        checks++; if (RegEn !== 1'b1 || aw !== 5'd21) $display("FAIL ovf_w21: got en=%0b aw=%0d exp en=1 aw=21", RegEn, aw); else passed++;
        @(negedge clk);
        #1;
        checks++; if (RegEn !== 1'b1 || aw !== 5'd22) $display("FAIL ovf_w22: got en=%0b aw=%0d exp en=1 aw=22", RegEn, aw); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++; if (RegEn !== 1'b0 || aw !== 5'd22) $display("FAIL ovf_dropped_%0d: got en=%0b aw=%0d exp en=0 aw=22", i, RegEn, aw); else passed++;
        end
        checks++; if (b_ovf !== 1'b1) $display("FAIL ovf_sticky: got %0b exp 1", b_ovf); else passed++;
    endtask

    task automatic test_zero_protect();
        do_reset();
        @(negedge clk);
        drive(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0);
        #1;
        checks++; if (a_ready !== 1'b1) $display("FAIL zp_ready: got %0b exp 1", a_ready); else passed++;
        @(negedge clk);
        drive(0, 0, 0, 1, 5'd9, 32'h99);
        #1;
        checks++; if (RegEn !== 1'b0) $display("FAIL zp_regen: got %0b exp 0", RegEn); else passed++;
        @(negedge clk);
        drive(1, 5'd4, 32'h44, 0, 0, 0);
        #1;
        checks++; if (a_ready !== 1'b0) $display("FAIL zp_b_wins: got rdy=%0b exp 0", a_ready); else passed++;
        @(negedge clk);
        #1;
        checks++; if (a_ready !== 1'b1) $display("FAIL zp_c3_ready: got %0b exp 1", a_ready); else passed++;
        checks++; if (RegEn !== 1'b1 || aw !== 5'd9 || dataIn_b !== 32'h99) $display("FAIL zp_wb: got en=%0b aw=%0d d=%h exp en=1 aw=9 d=99", RegEn, aw, dataIn_b); else passed++;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (RegEn !== 1'b1 || aw !== 5'd4 || dataIn_b !== 32'h44) $display("FAIL zp_wa: got en=%0b aw=%0d d=%h exp en=1 aw=4 d=44", RegEn, aw, dataIn_b); else passed++;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        @(negedge clk);
        drive(0, 0, 0, 1, 5'd14, 32'h1400);
        @(negedge clk);
        drive(1, 5'd6, 32'h600, 1, 5'd15, 32'h1500);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (RegEn !== 1'b1 || b_full !== 1'b1) $display("FAIL mid_pre: got en=%0b full=%0b exp en=1 full=1", RegEn, b_full); else passed++;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (RegEn !== 1'b0) $display("FAIL mid_async_regen: got %0b exp 0", RegEn); else passed++;
        checks++; if (b_full !== 1'b0 || aw !== 5'd0) $display("FAIL mid_async_clear: got full=%0b aw=%0d exp full=0 aw=0", b_full, aw); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++; if (RegEn !== 1'b0 || b_full !== 1'b0) $display("FAIL mid_stale_%0d: got en=%0b full=%0b exp en=0 full=0", i, RegEn, b_full); else passed++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        test_reset();
        test_contention();
        test_fifo_full();
        test_overflow();
        test_zero_protect();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/banco_wr_arbiter.md
# banco_wr_arbiter

Write-port arbiter and sequencer for the 32×32 register bank (`banco`). It shares the bank's single write port (`RegEn`, `aw`, `dataIn_b`) between two write-back sources:
- port A: ALU/immediate results, with a valid/ready handshake.
- port B: load returns, which cannot stall and are buffered in a small FIFO.

Grants alternate round-robin when both sources are pending. Every granted write is presented to the bank as a registered, single-cycle pulse.

## Interface
Parameters:
- `B_DEPTH`, default 2: entries in the port-B FIFO (power of two, ≥2).
- `ZERO_PROTECT`, default 1: if 1, writes to register 0 are consumed but never pulse `RegEn`.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `a_valid` in 1: port A has a write request.
- `a_addr` in 5: port A destination register.
- `a_data` in 32: port A write data.
- `a_ready` out 1: port A request accepted this cycle (combinational).
- `b_valid` in 1: port B load return; must be captured the same cycle.
- `b_addr` in 5: port B destination register.
- `b_data` in 32: port B write data.
- `b_full` out 1: port-B FIFO holds `B_DEPTH` entries.
- `b_ovf` out 1: sticky overflow error.
- `RegEn` out 1: bank write enable (registered).
- `aw` out 5: bank write address (registered).
- `dataIn_b` out 32: bank write data (registered).

## Operation
- **Reset** (`rst_n` low, asynchronous): the following are cleared:
  - outputs `RegEn`, `aw`, `dataIn_b`, `b_ovf`;
  - FIFO pointers and count;
  - `last_b`, which is set to 1 so that A wins the first contention.
- **Port-B FIFO:**
  - `b_valid` pushes {`b_addr`, `b_data`}.
  - The head is visible to the arbiter only from the cycle after the push; there is no same-cycle bypass.
  - Push and pop in the same cycle are legal at any occupancy, including full; the count is unchanged.
  - A push while full with no pop in that cycle drops the data and sets `b_ovf`. `b_ovf` stays set until reset.
- **Arbitration:** each cycle, with `b_pend` = FIFO non-empty:
  - Only `a_valid` set: grant A.
  - Only `b_pend` set: grant B.
  - Both set: grant A if `last_b`=1, otherwise grant B.
  - Neither set: no grant.
  - `a_ready` = grant to A. `a_ready` is 0 when `a_valid`=0.
  - A grant to B pops the FIFO head.
  - `last_b` updates only on a grant: 1 if B was granted, 0 if A was granted.
- **Output stage:**
  - On a grant, the winner's addr/data are loaded into `aw`/`dataIn_b`. `RegEn` is 1 for exactly the next cycle, then returns to 0 unless another grant occurs.
  - With no grant, `aw`/`dataIn_b` hold their values and `RegEn` is 0.
  - With `ZERO_PROTECT`=1 and a granted address of 0: the grant, pop and `last_b` update still happen, but `RegEn` stays 0.
- There is no stall path from the bank; one write per cycle is always drained.

## Timing
- Port A latency: accepted at edge n (`a_valid`&`a_ready`) → `RegEn`/`aw`/`dataIn_b` valid during cycle n+1.
- Port B latency: pushed at edge n → earliest grant in cycle n+1 → `RegEn` during cycle n+2.
- Sustained throughput: one bank write per cycle. Under continuous contention A and B alternate strictly.
- `a_ready` is combinational from `a_valid`, FIFO count and `last_b`. It has no combinational path from `b_valid`.
- Reset mid-operation: all FIFO contents and any in-flight write are discarded. `RegEn` drops immediately (asynchronously).
- The bank array itself is not reset.

## Structure
- Shared package `banco_pkg`:
  - `REG_AW`=5, `REG_DW`=32;
  - typedef `wr_req_t` {addr[4:0], data[31:0]}.
- One sub-module is natural: `banco_wr_fifo`. It is a parameterised synchronous FIFO of `wr_req_t` with push, pop, head, count, full and empty, plus the overflow detect.
- The arbiter, round-robin flag and output register live in the top level.

## Test plan
- **Reset:** hold `rst_n`=0 with random inputs → `RegEn`=0, `aw`=0, `dataIn_b`=0, `b_ovf`=0, `b_full`=0. After release, a single `a_valid` (addr 5, data 0xDEADBEEF) → `a_ready`=1; next cycle `RegEn`=1, `aw`=5, `dataIn_b`=0xDEADBEEF.
- **Contention:**
  - Setup: push B (addr 7, 0x11) in cycle 0, then hold `a_valid` (addr 3, 0x22) from cycle 1.
  - Cycle 1: A is granted.
  - Cycle 2: B is granted and `a_ready`=0.
  - Cycle 3: A is granted again.
  - Bank sees addresses 3, 7, 3 on consecutive `RegEn` pulses.
- **FIFO full, simultaneous events:**
  - With `a_valid` held and `last_b`=0 (so A loses the next contention), push B three times back-to-back with `B_DEPTH`=2.
  - Required: `b_full`=1 after two pushes.
  - The third push coincides with a B pop: no overflow, count stays 2.
- **Overflow:** keep A winning every B-free cycle, then push B with the FIFO full and no pop → `b_ovf`=1 and stays 1 after traffic stops. The dropped entry never appears on `aw`.
- **Zero protect:** `a_valid` with addr 0, data 0xFFFFFFFF → `a_ready`=1, `RegEn` stays 0. A subsequent B contention is granted to B, proving `last_b` was updated to A.
- **Reset mid-flight:** with the FIFO holding 2 entries and `RegEn`=1, assert `rst_n`=0 asynchronously mid-cycle → `RegEn`=0 immediately. After release, `b_full`=0 and no stale write is ever issued.
